// File: rtl/mac_alu.sv
`default_nettype none
// ============================================================================
// Module   : mac_alu
// Purpose  : Parametrised multiply/accumulate unit for the motor-control
//            datapath. Each accepted operation runs through a registered
//            product stage (MUL) and a registered result stage (ADD), then
//            waits in DONE until the consumer takes the result.
//              op = 00 MUL    : A*B
//              op = 01 MULADD : A*B + C
//              op = 10 MULSUB : A*B - C
//              op = 11 MAC    : acc + A*B, result also written back to acc
//            A transaction tag travels from key_in to key_out with the op.
//
// Parameters:
//   DATA_W  width of operands A and B
//   ACC_W   width of C, accumulator and result (>= 2*DATA_W)
//   KEY_W   width of the transaction tag
//   SIGNED  1 = two's complement arithmetic, 0 = unsigned
//
// Compile-time option:
//   ALU_SAT_EN  when defined, an overflowing result is clamped to the ACC_W
//               range (signed: max/min, unsigned: all-ones on carry, zero on
//               borrow). When undefined the result wraps modulo 2^ACC_W.
//               ovf reports the overflow in both builds.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 clear accumulator (acts even when en = 0)
//   en                  global enable; 0 freezes FSM, operands and outputs
//   op, in_a, in_b,
//   in_c, key_in        operation request fields
//   in_valid/in_ready   request handshake
//   out, key_out, ovf   result, its tag and the overflow flag
//   out_valid/out_ready result handshake
//
// Revision : 1.0 - initial release
// ============================================================================

module mac_alu #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int KEY_W  = 9,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [ACC_W-1:0]  in_c,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out,
    output logic [KEY_W-1:0]  key_out,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int   c_PROD_W = 2 * DATA_W;
    // Padding needed to bring the product up to the ACC_W+1 wide sum.
    localparam int   c_PAD_W  = ACC_W + 1 - c_PROD_W;
    localparam logic c_SIGNED = (SIGNED != 0);

    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULSUB = 2'b10;
    localparam logic [1:0] c_OP_MAC    = 2'b11;

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [ACC_W-1:0]    c_q;
    logic [1:0]          op_q;
    logic [KEY_W-1:0]    key_q;
    logic [c_PROD_W-1:0] prod_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    out_q;
    logic [KEY_W-1:0]    key_out_q;
    logic                ovf_q;
    logic                out_valid_q;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                w_accept;
    logic [c_PROD_W-1:0] w_a_ext;
    logic [c_PROD_W-1:0] w_b_ext;
    logic [c_PROD_W-1:0] w_prod;
    logic                w_is_mul;
    logic                w_is_sub;
    logic                w_is_mac;
    logic                w_prod_sign;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W:0]      w_prod_wide;
    logic [ACC_W:0]      w_addend_wide;
    logic [ACC_W:0]      w_sum;
    logic                w_ovf_raw;
    logic                w_ovf;
    logic [ACC_W-1:0]    w_result;

    // ------------------------------------------------------------------------
    // Multiplier. Both operands are extended to the full product width and
    // multiplied as plain vectors; the low 2*DATA_W bits of that product are
    // exact for both signed and unsigned operands, so one multiplier serves
    // either mode and maps directly onto a DSP block.
    // ------------------------------------------------------------------------
    generate
        if (SIGNED != 0) begin : g_signed_ext
            assign w_a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
            assign w_b_ext = {{DATA_W{b_q[DATA_W-1]}}, b_q};
        end else begin : g_unsigned_ext
            assign w_a_ext = {{DATA_W{1'b0}}, a_q};
            assign w_b_ext = {{DATA_W{1'b0}}, b_q};
        end
    endgenerate

    assign w_prod = w_a_ext * w_b_ext;

    // ------------------------------------------------------------------------
    // Result stage arithmetic. Everything is evaluated one bit wider than
    // ACC_W so that carry/borrow (unsigned) or sign overflow (signed) can be
    // read straight off the top two bits of the sum.
    // ------------------------------------------------------------------------
    assign w_is_mul = (op_q == c_OP_MUL);
    assign w_is_sub = (op_q == c_OP_MULSUB);
    assign w_is_mac = (op_q == c_OP_MAC);

    // A clear arriving in the ADD cycle of a MAC wins over the old acc value,
    // so the MAC result becomes the bare product.
    always_comb begin
        w_addend = c_q;
        if (w_is_mul) begin
            w_addend = {ACC_W{1'b0}};
        end else if (w_is_mac) begin
            w_addend = clr ? {ACC_W{1'b0}} : acc_q;
        end
    end

    assign w_prod_sign   = c_SIGNED & prod_q[c_PROD_W-1];
    assign w_prod_wide   = {{c_PAD_W{w_prod_sign}}, prod_q};
    assign w_addend_wide = {c_SIGNED & w_addend[ACC_W-1], w_addend};
    assign w_sum         = w_is_sub ? (w_prod_wide - w_addend_wide)
                                    : (w_prod_wide + w_addend_wide);

    // Signed: the ACC_W+1 sum is exact, so overflow shows as disagreement
    // between its top bit and the ACC_W result's sign bit.
    // Unsigned: the top bit is the carry (add) or the borrow (sub).
    assign w_ovf_raw = c_SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    assign w_ovf     = w_ovf_raw & ~w_is_mul;

    always_comb begin
        w_result = w_sum[ACC_W-1:0];
`ifdef ALU_SAT_EN
        if (w_ovf) begin
            if (c_SIGNED) begin
                // Top bit of the exact sum is the true sign of the result.
                w_result = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                w_result = w_is_sub ? {ACC_W{1'b0}} : {ACC_W{1'b1}};
            end
        end
`endif
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state. With en low nothing advances.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        w_accept = 1'b1;
                        state_d  = S_MUL;
                    end
                end
                S_MUL:  state_d = S_ADD;
                S_ADD:  state_d = S_DONE;
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign in_ready = en && (state_q == S_IDLE);

    // ------------------------------------------------------------------------
    // Operand, product and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            op_q        <= '0;
            key_q       <= '0;
            prod_q      <= '0;
            out_q       <= '0;
            key_out_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            if (w_accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                c_q   <= in_c;
                op_q  <= op;
                key_q <= key_in;
            end

            if (state_q == S_MUL) begin
                prod_q <= w_prod;
            end

            if (state_q == S_ADD) begin
                out_q       <= w_result;
                key_out_q   <= key_q;
                ovf_q       <= w_ovf;
                out_valid_q <= 1'b1;
            end

            // out_valid is only ever high in DONE, so out_ready outside that
            // state has no effect.
            if ((state_q == S_DONE) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator. The clear acts regardless of en; a MAC completing in the
    // same cycle already folded the clear into its result.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en && (state_q == S_ADD) && w_is_mac) begin
            acc_q <= w_result;
        end else if (clr) begin
            acc_q <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out       = out_q;
    assign key_out   = key_out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire
